// File: rtl/dic_alarm_ring_ctrl_if.sv
// Signal bundle between the alarm ring controller and its surroundings:
// time/alarm digits, clock status, key strobes and the ring status outputs.
interface dic_alarm_ring_ctrl_if;
  logic       secStrobe;
  logic       dicRun;
  logic       alarm_activated;
  logic [3:0] t_Mtens;
  logic [3:0] t_Mones;
  logic [3:0] t_Stens;
  logic [3:0] t_Sones;
  logic [3:0] a_Mtens;
  logic [3:0] a_Mones;
  logic [3:0] a_Stens;
  logic [3:0] a_Sones;
  logic       det_dismiss;
  logic       det_snooze;
  logic       ring;
  logic       ring_blink;
  logic       snoozing;
  logic [1:0] snooze_cnt;
  logic [7:0] ring_char;

  modport master (
    output secStrobe, dicRun, alarm_activated,
    output t_Mtens, t_Mones, t_Stens, t_Sones,
    output a_Mtens, a_Mones, a_Stens, a_Sones,
    output det_dismiss, det_snooze,
    input  ring, ring_blink, snoozing, snooze_cnt, ring_char
  );

  modport slave (
    input  secStrobe, dicRun, alarm_activated,
    input  t_Mtens, t_Mones, t_Stens, t_Sones,
    input  a_Mtens, a_Mones, a_Stens, a_Sones,
    input  det_dismiss, det_snooze,
    output ring, ring_blink, snoozing, snooze_cnt, ring_char
  );
endinterface

// File: rtl/dic_alarm_ring_ctrl.sv
// Alarm ring sequencer for the digital clock: detects the rising edge of the
// time==alarm match, rings, and handles dismiss, snooze and auto-timeout.
//
//   state    | meaning
//   DISARMED | alarm not armed, outputs idle
//   ARMED    | waiting for a match edge while the clock runs
//   RINGING  | alarm sounding, ring_blink toggles per second
//   SNOOZE   | silent snooze interval, returns to RINGING on timeout
module dic_alarm_ring_ctrl #(
  parameter int RING_SECS   = 30,
  parameter int SNOOZE_SECS = 10,
  parameter int MAX_SNOOZE  = 3
) (
  input logic                  clk,
  input logic                  rst,
  dic_alarm_ring_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } state_t;

  localparam logic [7:0] RING_TC    = 8'(RING_SECS - 1);
  localparam logic [7:0] SNOOZE_TC  = 8'(SNOOZE_SECS - 1);
  localparam logic [1:0] SNOOZE_LIM = 2'(MAX_SNOOZE);

  localparam logic [7:0] CHAR_BANG  = 8'h21;
  localparam logic [7:0] CHAR_STAR  = 8'h2A;
  localparam logic [7:0] CHAR_Z     = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] sec_cnt;
  logic [1:0] snooze_cnt_q;
  logic [1:0] snooze_cnt_nxt;
  logic       match;
  logic       match_q;
  logic       trigger;
  logic       ring_q;
  logic       blink_q;
  logic       blink_nxt;
  logic       snoozing_q;
  logic [7:0] char_q;
  logic [7:0] char_nxt;

  assign match = ({bus.t_Mtens, bus.t_Mones, bus.t_Stens, bus.t_Sones} ==
                  {bus.a_Mtens, bus.a_Mones, bus.a_Stens, bus.a_Sones});

  // Only a fresh match while the clock runs starts an alarm, so a stopped
  // clock parked on the alarm time cannot retrigger.
  assign trigger = match & ~match_q & bus.dicRun;

  // Next-state and next-output decode; key priority is
  // disarm > dismiss > snooze > second timeout.
  always_comb begin
    state_nxt      = state;
    snooze_cnt_nxt = snooze_cnt_q;
    blink_nxt      = 1'b0;
    char_nxt       = CHAR_SPACE;
    case (state)
      DISARMED: begin
        if (bus.alarm_activated) state_nxt = ARMED;
      end
      ARMED: begin
        if (!bus.alarm_activated) begin
          state_nxt = DISARMED;
        end else if (trigger) begin
          state_nxt      = RINGING;
          snooze_cnt_nxt = 2'd0;
        end
      end
      RINGING: begin
        if (!bus.alarm_activated) begin
          state_nxt = DISARMED;
        end else if (bus.det_dismiss) begin
          state_nxt = ARMED;
        end else if (bus.det_snooze && (snooze_cnt_q < SNOOZE_LIM)) begin
          state_nxt      = SNOOZE;
          snooze_cnt_nxt = snooze_cnt_q + 2'd1;
        end else if (bus.secStrobe && (sec_cnt == RING_TC)) begin
          state_nxt = ARMED;
        end
      end
      SNOOZE: begin
        if (!bus.alarm_activated) begin
          state_nxt = DISARMED;
        end else if (bus.det_dismiss) begin
          state_nxt = ARMED;
        end else if (bus.secStrobe && (sec_cnt == SNOOZE_TC)) begin
          state_nxt = RINGING;
        end
      end
      default: state_nxt = DISARMED;
    endcase

    if (state_nxt == RINGING) begin
      if (state != RINGING)   blink_nxt = 1'b1;
      else if (bus.secStrobe) blink_nxt = ~blink_q;
      else                    blink_nxt = blink_q;
      char_nxt = blink_nxt ? CHAR_BANG : CHAR_STAR;
    end else if (state_nxt == SNOOZE) begin
      char_nxt = CHAR_Z;
    end
  end

  // State, seconds counter and match history; the counter restarts on
  // every state change so each state times from its own entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DISARMED;
      sec_cnt      <= 8'd0;
      match_q      <= 1'b0;
      snooze_cnt_q <= 2'd0;
    end else begin
      state        <= state_nxt;
      match_q      <= match;
      snooze_cnt_q <= snooze_cnt_nxt;
      if (state_nxt != state)  sec_cnt <= 8'd0;
      else if (bus.secStrobe)  sec_cnt <= sec_cnt + 8'd1;
    end
  end

  // Registered Moore outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ring_q     <= 1'b0;
      blink_q    <= 1'b0;
      snoozing_q <= 1'b0;
      char_q     <= CHAR_SPACE;
    end else begin
      ring_q     <= (state_nxt == RINGING);
      blink_q    <= blink_nxt;
      snoozing_q <= (state_nxt == SNOOZE);
      char_q     <= char_nxt;
    end
  end

  assign bus.ring       = ring_q;
  assign bus.ring_blink = blink_q;
  assign bus.snoozing   = snoozing_q;
  assign bus.snooze_cnt = snooze_cnt_q;
  assign bus.ring_char  = char_q;

endmodule

// File: tb/tb_dic_alarm_ring_ctrl.sv
// Directed bench for the alarm ring controller (default parameters 30/10/3).
module tb_dic_alarm_ring_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  localparam logic [7:0] C_BANG  = 8'h21;
  localparam logic [7:0] C_STAR  = 8'h2A;
  localparam logic [7:0] C_Z     = 8'h7A;
  localparam logic [7:0] C_SPACE = 8'h20;

  dic_alarm_ring_ctrl_if bus ();

  dic_alarm_ring_ctrl #(
    .RING_SECS  (30),
    .SNOOZE_SECS(10),
    .MAX_SNOOZE (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int n);
    for (int i = 0; i < n; i++) begin
      bus.secStrobe = 1'b1;
      tick();
      bus.secStrobe = 1'b0;
    end
  endtask

  task automatic set_time(input logic [3:0] mt, input logic [3:0] mo,
                          input logic [3:0] st, input logic [3:0] so);
    bus.t_Mtens = mt;
    bus.t_Mones = mo;
    bus.t_Stens = st;
    bus.t_Sones = so;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic r, input logic b,
                           input logic s, input logic [1:0] c, input logic [7:0] ch);
    check({tag, ".ring"},       {7'd0, bus.ring},       {7'd0, r});
    check({tag, ".ring_blink"}, {7'd0, bus.ring_blink}, {7'd0, b});
    check({tag, ".snoozing"},   {7'd0, bus.snoozing},   {7'd0, s});
    check({tag, ".snooze_cnt"}, {6'd0, bus.snooze_cnt}, {6'd0, c});
    check({tag, ".ring_char"},  bus.ring_char,          ch);
  endtask

  // Move the time off the alarm and back onto it to produce a match edge.
  task automatic retrigger();
    set_time(4'd0, 4'd1, 4'd3, 4'd1);
    tick();
    set_time(4'd0, 4'd1, 4'd3, 4'd0);
    tick();
  endtask

  initial begin
    bus.secStrobe       = 1'b0;
    bus.dicRun          = 1'b0;
    bus.alarm_activated = 1'b0;
    bus.det_dismiss     = 1'b0;
    bus.det_snooze      = 1'b0;
    set_time(4'd0, 4'd0, 4'd0, 4'd0);
    bus.a_Mtens = 4'd0;
    bus.a_Mones = 4'd1;
    bus.a_Stens = 4'd3;
    bus.a_Sones = 4'd0;

    // Reset state
    tick();
    tick();
    check_all("reset", 1'b0, 1'b0, 1'b0, 2'd0, C_SPACE);
    rst = 1'b0;

    // 1: arm, run 01:29 -> 01:30, ring one cycle after the match edge
    bus.alarm_activated = 1'b1;
    tick();
    bus.dicRun = 1'b1;
    set_time(4'd0, 4'd1, 4'd2, 4'd9);
    tick();
    check_all("t1_before", 1'b0, 1'b0, 1'b0, 2'd0, C_SPACE);
    set_time(4'd0, 4'd1, 4'd3, 4'd0);
    tick();
    check_all("t1_ring", 1'b1, 1'b1, 1'b0, 2'd0, C_BANG);
    strobe(1);
    check_all("t1_blink0", 1'b1, 1'b0, 1'b0, 2'd0, C_STAR);
    strobe(1);
    check_all("t1_blink1", 1'b1, 1'b1, 1'b0, 2'd0, C_BANG);

    // 2: auto-off on the 30th strobe, no retrigger with the clock stopped
    strobe(27);
    check("t2_29th.ring", {7'd0, bus.ring}, 8'd1);
    strobe(1);
    check_all("t2_autooff", 1'b0, 1'b0, 1'b0, 2'd0, C_SPACE);
    bus.dicRun = 1'b0;
    tick();
    retrigger();
    tick();
    check("t2_stopped.ring", {7'd0, bus.ring}, 8'd0);

    // 3: snooze three times, fourth snooze is ignored
    bus.dicRun = 1'b1;
    retrigger();
    check_all("t3_ring", 1'b1, 1'b1, 1'b0, 2'd0, C_BANG);
    for (int k = 1; k <= 3; k++) begin
      bus.det_snooze = 1'b1;
      tick();
      bus.det_snooze = 1'b0;
      check_all("t3_snooze", 1'b0, 1'b0, 1'b1, 2'(k), C_Z);
      strobe(9);
      check("t3_snooze9.snoozing", {7'd0, bus.snoozing}, 8'd1);
      strobe(1);
      check_all("t3_resume", 1'b1, 1'b1, 1'b0, 2'(k), C_BANG);
    end
    bus.det_snooze = 1'b1;
    tick();
    bus.det_snooze = 1'b0;
    check_all("t3_limit", 1'b1, 1'b1, 1'b0, 2'd3, C_BANG);

    // 4: dismiss and snooze together -> ARMED, snooze_cnt unchanged
    bus.det_dismiss = 1'b1;
    tick();
    bus.det_dismiss = 1'b0;
    check_all("t4_dismiss_lim", 1'b0, 1'b0, 1'b0, 2'd3, C_SPACE);
    retrigger();
    check_all("t4_ring", 1'b1, 1'b1, 1'b0, 2'd0, C_BANG);
    bus.det_snooze = 1'b1;
    tick();
    bus.det_snooze = 1'b0;
    strobe(10);
    check_all("t4_resume", 1'b1, 1'b1, 1'b0, 2'd1, C_BANG);
    bus.det_dismiss = 1'b1;
    bus.det_snooze  = 1'b1;
    tick();
    bus.det_dismiss = 1'b0;
    bus.det_snooze  = 1'b0;
    check_all("t4_both", 1'b0, 1'b0, 1'b0, 2'd1, C_SPACE);

    // 5: disarm during snooze, then a match edge while disarmed
    retrigger();
    check("t5_ring.ring", {7'd0, bus.ring}, 8'd1);
    bus.det_snooze = 1'b1;
    tick();
    bus.det_snooze = 1'b0;
    check_all("t5_snooze", 1'b0, 1'b0, 1'b1, 2'd1, C_Z);
    bus.alarm_activated = 1'b0;
    tick();
    check_all("t5_disarm", 1'b0, 1'b0, 1'b0, 2'd1, C_SPACE);
    retrigger();
    tick();
    check("t5_disarmed_match.ring", {7'd0, bus.ring}, 8'd0);

    // 6: reset mid-ring with a strobe present
    bus.alarm_activated = 1'b1;
    tick();
    retrigger();
    strobe(1);
    check_all("t6_ring", 1'b1, 1'b0, 1'b0, 2'd0, C_STAR);
    rst = 1'b1;
    bus.secStrobe = 1'b1;
    tick();
    bus.secStrobe = 1'b0;
    check_all("t6_reset", 1'b0, 1'b0, 1'b0, 2'd0, C_SPACE);
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
